shift_ser_out_ctrl: RTL and testbench

SHIFT_SER_OUT_CTRL -- requirements
Module: shift_ser_out_ctrl

---
 rtl/shift_ser_out_ctrl.sv | 110 +++++++++++
 tb/tb_shift_ser_out_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_ser_out_ctrl.sv
// Serialises a WIDTH-bit word MSB first into a 74LV595 (SER/SRCLK/RCLK).
// Shift clock runs at clk/2; every pin is driven straight from a flop.
module shift_ser_out_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] data,
   output logic             o_ser,
   output logic             o_srclk,
   output logic             o_rclk,
   output logic             o_busy,
   output logic             o_done
);

   // {bit index, phase}; phase is the LSB so the counter itself divides clk by 2
   localparam int unsigned         CntW    = $clog2(WIDTH) + 1;
   localparam logic [CntW-1:0]     CntLast = CntW'(2 * WIDTH - 1);
   localparam logic [CntW-1:0]     CntOne  = CntW'(1);

   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StLatch,
      StDone
   } state_e;

   state_e           state_q;
   logic [WIDTH-1:0] shreg_q;
   logic [CntW-1:0]  cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         shreg_q <= '0;
         cnt_q   <= '0;
         o_ser   <= 1'b0;
         o_srclk <= 1'b0;
         o_rclk  <= 1'b0;
         o_busy  <= 1'b0;
         o_done  <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               o_ser   <= 1'b0;
               o_srclk <= 1'b0;
               o_rclk  <= 1'b0;
               o_busy  <= 1'b0;
               o_done  <= 1'b0;
               if (start) begin
                  shreg_q <= data;
                  cnt_q   <= '0;
                  o_ser   <= data[WIDTH-1];
                  o_busy  <= 1'b1;
                  state_q <= StShift;
               end
            end

            StShift: begin
               if (!cnt_q[0]) begin
                  o_srclk <= 1'b1;
                  cnt_q   <= cnt_q + CntOne;
               end else begin
                  o_srclk <= 1'b0;
                  shreg_q <= shreg_q << 1;
                  if (cnt_q == CntLast) begin
                     o_ser   <= 1'b0;
                     cnt_q   <= '0;
                     state_q <= StLatch;
                  end else begin
                     // next MSB goes out with the falling SRCLK: a full cycle of setup
                     o_ser   <= shreg_q[WIDTH-2];
                     cnt_q   <= cnt_q + CntOne;
                  end
               end
            end

            StLatch: begin
               if (!cnt_q[0]) begin
                  o_rclk <= 1'b1;
                  cnt_q  <= cnt_q + CntOne;
               end else begin
                  o_rclk  <= 1'b0;
                  o_done  <= 1'b1;
                  cnt_q   <= '0;
                  state_q <= StDone;
               end
            end

            StDone: begin
               o_done  <= 1'b0;
               o_busy  <= 1'b0;
               state_q <= StIdle;
            end

            default: begin
               o_ser   <= 1'b0;
               o_srclk <= 1'b0;
               o_rclk  <= 1'b0;
               o_busy  <= 1'b0;
               o_done  <= 1'b0;
               cnt_q   <= '0;
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_ser_out_ctrl.sv
// Bench for shift_ser_out_ctrl: cycle-count reference model, 595 model,
// vector table, corner-case sequences and randomized traffic.
module tb_shift_ser_out_ctrl;
   localparam int W  = 8;
   localparam int W2 = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          start = 1'b0, start2 = 1'b0;
   logic [W-1:0]  data = '0;
   logic [W2-1:0] data2 = '0;
   logic          ser, srclk, rclk, busy, done;
   logic          ser2, srclk2, rclk2, busy2, done2;

   int tests = 0;
   int fails = 0;
   int edge_cnt = 0;

   shift_ser_out_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .data(data),
      .o_ser(ser), .o_srclk(srclk), .o_rclk(rclk), .o_busy(busy), .o_done(done)
   );

   shift_ser_out_ctrl #(.WIDTH(W2)) dut2 (
      .clk(clk), .reset(reset), .start(start2), .data(data2),
      .o_ser(ser2), .o_srclk(srclk2), .o_rclk(rclk2), .o_busy(busy2), .o_done(done2)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   // Reference: t = cycles since the accepting edge (0 = idle); a transfer spans 2W+3 cycles
   int          ref_t = 0, ref_t2 = 0;
   logic [31:0] ref_d = '0, ref_d2 = '0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         ref_t <= 0;
         ref_d <= '0;
      end else if (ref_t == 0) begin
         if (start) begin
            ref_t <= 1;
            ref_d <= 32'(data);
         end
      end else if (ref_t == 2 * W + 3) ref_t <= 0;
      else ref_t <= ref_t + 1;
   end

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         ref_t2 <= 0;
         ref_d2 <= '0;
      end else if (ref_t2 == 0) begin
         if (start2) begin
            ref_t2 <= 1;
            ref_d2 <= 32'(data2);
         end
      end else if (ref_t2 == 2 * W2 + 3) ref_t2 <= 0;
      else ref_t2 <= ref_t2 + 1;
   end

   // Expected {ser, srclk, rclk, busy, done} for cycle t of a w-bit transfer of d
   function automatic logic [4:0] expect_out(input int t, input int w, input logic [31:0] d);
      logic [4:0] e;
      e = '0;
      if (t >= 1 && t <= 2 * w) begin
         e[4] = d[w - 1 - (t - 1) / 2];
         e[3] = (t % 2 == 0);
         e[1] = 1'b1;
      end else if (t == 2 * w + 1) begin
         e[1] = 1'b1;
      end else if (t == 2 * w + 2) begin
         e[2] = 1'b1;
         e[1] = 1'b1;
      end else if (t == 2 * w + 3) begin
         e[0] = 1'b1;
         e[1] = 1'b1;
      end
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // 595 models and edge bookkeeping, sampled on the falling clk edge
   logic          prev_srclk = 1'b0, prev_rclk = 1'b0, prev_srclk2 = 1'b0, prev_rclk2 = 1'b0;
   logic [W-1:0]  sr595 = '0, q595 = '0, ser_bits = '0;
   logic [W2-1:0] sr2 = '0, q2 = '0, ser_bits2 = '0;
   int srclk_rises = 0, rclk_rises = 0, done_cnt = 0, rclk_cyc = 0, done_cyc = 0, e0 = 0;
   int srclk_rises2 = 0, rclk_cyc2 = 0, done_cyc2 = 0, e0_2 = 0;
   logic [W-1:0]  latch_q[$];

   initial begin
      forever begin
         @(negedge clk);
         check("cycle_w8", 32'({ser, srclk, rclk, busy, done}), 32'(expect_out(ref_t, W, ref_d)));
         check("cycle_w2", 32'({ser2, srclk2, rclk2, busy2, done2}),
               32'(expect_out(ref_t2, W2, ref_d2)));
         if (srclk && !prev_srclk) begin
            sr595    = {sr595[W-2:0], ser};
            ser_bits = {ser_bits[W-2:0], ser};
            srclk_rises++;
         end
         if (rclk && !prev_rclk) begin
            q595 = sr595;
            latch_q.push_back(sr595);
            rclk_rises++;
            rclk_cyc = edge_cnt - e0 + 1;
            check("latch_vs_model_w8", 32'(q595), 32'(ref_d[W-1:0]));
         end
         if (done) begin
            done_cnt++;
            done_cyc = edge_cnt - e0 + 1;
         end
         if (srclk2 && !prev_srclk2) begin
            sr2       = {sr2[W2-2:0], ser2};
            ser_bits2 = {ser_bits2[W2-2:0], ser2};
            srclk_rises2++;
         end
         if (rclk2 && !prev_rclk2) begin
            q2        = sr2;
            rclk_cyc2 = edge_cnt - e0_2 + 1;
            check("latch_vs_model_w2", 32'(q2), 32'(ref_d2[W2-1:0]));
         end
         if (done2) done_cyc2 = edge_cnt - e0_2 + 1;
         prev_srclk  = srclk;
         prev_rclk   = rclk;
         prev_srclk2 = srclk2;
         prev_rclk2  = rclk2;
      end
   end

   task automatic clear_counts();
      srclk_rises  = 0;
      rclk_rises   = 0;
      done_cnt     = 0;
      rclk_cyc     = 0;
      done_cyc     = 0;
      srclk_rises2 = 0;
      rclk_cyc2    = 0;
      done_cyc2    = 0;
      latch_q.delete();
   endtask

   // Returns one time unit into cycle 1 of the transfer
   task automatic send(input logic [W-1:0] d);
      @(posedge clk);
      #1;
      start = 1'b1;
      data  = d;
      @(posedge clk);
      #1;
      e0    = edge_cnt;
      start = 1'b0;
   endtask

   task automatic send2(input logic [W2-1:0] d);
      @(posedge clk);
      #1;
      start2 = 1'b1;
      data2  = d;
      @(posedge clk);
      #1;
      e0_2   = edge_cnt;
      start2 = 1'b0;
   endtask

   task automatic wait_idle(input bit second, input string name);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((second ? busy2 : busy) && n < 80);
      #1;
      check(name, 32'(second ? busy2 : busy), 32'(0));
   endtask

   typedef struct {
      logic [W-1:0] d;
      logic [W-1:0] exp_ser;
      logic [W-1:0] exp_q;
      int           exp_rclk;
      int           exp_done;
      int           exp_rises;
   } vec_t;

   vec_t vecs[6];

   initial begin
      vecs[0] = '{8'hA5, 8'hA5, 8'hA5, 18, 19, 8};
      vecs[1] = '{8'h3C, 8'h3C, 8'h3C, 18, 19, 8};
      vecs[2] = '{8'h01, 8'h01, 8'h01, 18, 19, 8};
      vecs[3] = '{8'h80, 8'h80, 8'h80, 18, 19, 8};
      vecs[4] = '{8'hFF, 8'hFF, 8'hFF, 18, 19, 8};
      vecs[5] = '{8'h00, 8'h00, 8'h00, 18, 19, 8};

      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", 32'({ser, srclk, rclk, busy, done}), 32'(0));
      @(posedge clk);
      #1;
      reset = 1'b0;

      for (int i = 0; i < 6; i++) begin
         clear_counts();
         send(vecs[i].d);
         wait_idle(1'b0, "vec_idle");
         check("vec_ser_bits", 32'(ser_bits), 32'(vecs[i].exp_ser));
         check("vec_latched", 32'(q595), 32'(vecs[i].exp_q));
         check("vec_rclk_cycle", rclk_cyc, vecs[i].exp_rclk);
         check("vec_done_cycle", done_cyc, vecs[i].exp_done);
         check("vec_srclk_rises", srclk_rises, vecs[i].exp_rises);
         check("vec_done_count", done_cnt, 1);
      end

      // Back-to-back with start held: second SHIFT begins in cycle 21
      clear_counts();
      @(posedge clk);
      #1;
      start = 1'b1;
      data  = 8'hFF;
      @(posedge clk);
      #1;
      e0   = edge_cnt;
      data = 8'h00;
      repeat (19) @(posedge clk);
      @(negedge clk);
      #1;
      check("b2b_idle_gap", 32'(busy), 32'(0));
      @(negedge clk);
      #1;
      check("b2b_second_busy", 32'(busy), 32'(1));
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_idle(1'b0, "b2b_idle");
      check("b2b_srclk_rises", srclk_rises, 16);
      check("b2b_rclk_rises", rclk_rises, 2);
      check("b2b_latch_count", latch_q.size(), 2);
      if (latch_q.size() == 2) begin
         check("b2b_first_latch", 32'(latch_q[0]), 32'h0000_00FF);
         check("b2b_second_latch", 32'(latch_q[1]), 32'h0000_0000);
      end

      // Start pulses in cycles 5 and 17 are ignored
      clear_counts();
      send(8'h96);
      repeat (4) @(posedge clk);
      #1;
      start = 1'b1;
      data  = 8'h11;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (11) @(posedge clk);
      #1;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_idle(1'b0, "ignore_idle");
      check("ignore_done_count", done_cnt, 1);
      check("ignore_srclk_rises", srclk_rises, 8);
      check("ignore_latched", 32'(q595), 32'h0000_0096);

      // Data change after acceptance has no effect
      clear_counts();
      send(8'h3C);
      repeat (3) @(posedge clk);
      #1;
      data = 8'hC3;
      wait_idle(1'b0, "datachg_idle");
      check("datachg_latched", 32'(q595), 32'h0000_003C);

      // Reset mid-cycle 7 aborts without an RCLK pulse
      clear_counts();
      send(8'hE7);
      repeat (6) @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check("abort_outputs_now", 32'({ser, srclk, rclk, busy, done}), 32'(0));
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("abort_no_rclk", rclk_rises, 0);
      check("abort_latch_kept", 32'(q595), 32'h0000_003C);
      send(8'h5A);
      wait_idle(1'b0, "after_abort_idle");
      check("after_abort_latched", 32'(q595), 32'h0000_005A);
      check("after_abort_rclk", rclk_rises, 1);

      // WIDTH=2 instance
      clear_counts();
      send2(2'b10);
      wait_idle(1'b1, "w2_idle");
      check("w2_ser_bits", 32'(ser_bits2), 32'h2);
      check("w2_srclk_rises", srclk_rises2, 2);
      check("w2_rclk_cycle", rclk_cyc2, 6);
      check("w2_done_cycle", done_cyc2, 7);
      check("w2_latched", 32'(q2), 32'h2);

      // Random traffic against the cycle model on both instances
      for (int c = 0; c < 800; c++) begin
         @(posedge clk);
         #1;
         start  = ($urandom_range(0, 3) == 0);
         data   = W'($urandom);
         start2 = ($urandom_range(0, 2) == 0);
         data2  = W2'($urandom);
      end
      start  = 1'b0;
      start2 = 1'b0;
      wait_idle(1'b0, "rand_idle_w8");
      wait_idle(1'b1, "rand_idle_w2");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
